// File: rtl/coin_collector_if.sv
// Bundle between the user panel / vending core and the coin collector.
// The collector connects through the slave modport; the panel/core side uses master.
interface coin_collector_if;
    logic       coinValid;
    logic [1:0] coinType;
    logic [1:0] itemSel;
    logic       cancel;
    logic [1:0] serviceTypeIn;
    logic [1:0] coinInNTD_50;
    logic [1:0] coinInNTD_10;
    logic [1:0] coinInNTD_5;
    logic [1:0] coinInNTD_1;
    logic [1:0] itemTypeIn;
    logic [7:0] credit;
    logic       coinReject;
    logic       refundValid;
    logic       busy;
    logic       txnDone;
    logic       fault;

    modport master (
        output coinValid, coinType, itemSel, cancel, serviceTypeIn,
        input  coinInNTD_50, coinInNTD_10, coinInNTD_5, coinInNTD_1,
        input  itemTypeIn, credit, coinReject, refundValid, busy, txnDone, fault
    );

    modport slave (
        input  coinValid, coinType, itemSel, cancel, serviceTypeIn,
        output coinInNTD_50, coinInNTD_10, coinInNTD_5, coinInNTD_1,
        output itemTypeIn, credit, coinReject, refundValid, busy, txnDone, fault
    );
endinterface

// File: rtl/coin_collector.sv
// Coin collector front end: counts coins per denomination, hands one transaction
// to the vending core, and refunds on cancel or inactivity timeout.
module coin_collector #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int WAIT_LIMIT     = 64
) (
    input  logic             clk,
    input  logic             reset,
    coin_collector_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        ISSUE,
        WAIT_DONE,
        REFUND
    } stateT;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] WAIT_LAST    = 8'(WAIT_LIMIT - 1);

    stateT      state;
    logic [1:0] coinCount [4];
    logic [7:0] creditReg;
    logic [1:0] itemReg;
    logic [7:0] idleTimer;
    logic [7:0] waitTimer;
    logic       rejectReg;
    logic       refundReg;
    logic       busyReg;
    logic       doneReg;
    logic       faultReg;

    logic [7:0] coinValue;
    logic       canAccept;
    logic       activity;

    // Count index follows coinType encoding: 0=NTD50, 1=NTD10, 2=NTD5, 3=NTD1.
    always_comb begin
        coinValue = 8'd0;
        unique case (bus.coinType)
            2'b00: coinValue = 8'd50;
            2'b01: coinValue = 8'd10;
            2'b10: coinValue = 8'd5;
            2'b11: coinValue = 8'd1;
        endcase
    end

    assign canAccept = (coinCount[bus.coinType] != 2'd3);
    assign activity  = bus.coinValid || (bus.itemSel != 2'b00) || bus.cancel;

    // Coin acceptance runs ahead of the state case so a coin arriving with
    // cancel/select is already in the counts that get refunded or issued.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            for (int i = 0; i < 4; i++) coinCount[i] <= 2'd0;
            creditReg <= 8'd0;
            itemReg   <= 2'b00;
            idleTimer <= 8'd0;
            waitTimer <= 8'd0;
            rejectReg <= 1'b0;
            refundReg <= 1'b0;
            busyReg   <= 1'b0;
            doneReg   <= 1'b0;
            faultReg  <= 1'b0;
        end else begin
            rejectReg <= 1'b0;
            refundReg <= 1'b0;
            doneReg   <= 1'b0;

            if (bus.coinValid) begin
                if ((state == IDLE || state == COLLECT) && canAccept) begin
                    coinCount[bus.coinType] <= coinCount[bus.coinType] + 2'd1;
                    creditReg <= creditReg + coinValue;
                end else begin
                    rejectReg <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (bus.coinValid) begin
                        idleTimer <= 8'd0;
                        state     <= COLLECT;
                    end
                end

                COLLECT: begin
                    if (bus.cancel) begin
                        idleTimer <= 8'd0;
                        refundReg <= 1'b1;
                        busyReg   <= 1'b1;
                        state     <= REFUND;
                    end else if (bus.itemSel != 2'b00) begin
                        idleTimer <= 8'd0;
                        itemReg   <= bus.itemSel;
                        busyReg   <= 1'b1;
                        state     <= ISSUE;
                    end else if (activity) begin
                        idleTimer <= 8'd0;
                    end else if (idleTimer == TIMEOUT_LAST) begin
                        idleTimer <= 8'd0;
                        refundReg <= 1'b1;
                        busyReg   <= 1'b1;
                        state     <= REFUND;
                    end else begin
                        idleTimer <= idleTimer + 8'd1;
                    end
                end

                ISSUE: begin
                    if (bus.serviceTypeIn == 2'b01) begin
                        for (int i = 0; i < 4; i++) coinCount[i] <= 2'd0;
                        creditReg <= 8'd0;
                        itemReg   <= 2'b00;
                        waitTimer <= 8'd0;
                        state     <= WAIT_DONE;
                    end
                end

                WAIT_DONE: begin
                    if (bus.serviceTypeIn == 2'b00) begin
                        doneReg <= 1'b1;
                        busyReg <= 1'b0;
                        state   <= IDLE;
                    end else if (waitTimer == WAIT_LAST) begin
                        faultReg <= 1'b1;
                        busyReg  <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        waitTimer <= waitTimer + 8'd1;
                    end
                end

                REFUND: begin
                    for (int i = 0; i < 4; i++) coinCount[i] <= 2'd0;
                    creditReg <= 8'd0;
                    busyReg   <= 1'b0;
                    state     <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.coinInNTD_50 = coinCount[0];
    assign bus.coinInNTD_10 = coinCount[1];
    assign bus.coinInNTD_5  = coinCount[2];
    assign bus.coinInNTD_1  = coinCount[3];
    assign bus.itemTypeIn   = itemReg;
    assign bus.credit       = creditReg;
    assign bus.coinReject   = rejectReg;
    assign bus.refundValid  = refundReg;
    assign bus.busy         = busyReg;
    assign bus.txnDone      = doneReg;
    assign bus.fault        = faultReg;

endmodule

// File: tb/tb_coin_collector.sv
// Scoreboard bench for coin_collector: stimulus queues expected snapshots, a
// monitor compares them on output events (pulses, issue, fault) or at set cycles.
module tb_coin_collector;

    typedef struct packed {
        logic [1:0] c50;
        logic [1:0] c10;
        logic [1:0] c5;
        logic [1:0] c1;
        logic [1:0] item;
        logic [7:0] credit;
        logic       rej;
        logic       refv;
        logic       busy;
        logic       done;
        logic       fault;
    } snapT;

    typedef struct {
        string label;
        int    atCycle;
        snapT  exp;
    } expT;

    logic clk;
    logic reset;
    int   cycleCount;
    int   checks;
    int   errors;
    expT  evtQ[$];
    expT  probeQ[$];

    coin_collector_if bus();

    coin_collector #(
        .TIMEOUT_CYCLES(16),
        .WAIT_LIMIT(64)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cycleCount = 0;
        forever begin
            @(posedge clk);
            cycleCount++;
        end
    end

    function automatic snapT mk(input int c50, input int c10, input int c5, input int c1,
                                input int item, input int credit, input int rej,
                                input int refv, input int busy, input int done, input int fault);
        snapT s;
        s.c50 = 2'(c50); s.c10 = 2'(c10); s.c5 = 2'(c5); s.c1 = 2'(c1);
        s.item = 2'(item); s.credit = 8'(credit);
        s.rej = 1'(rej); s.refv = 1'(refv); s.busy = 1'(busy);
        s.done = 1'(done); s.fault = 1'(fault);
        return s;
    endfunction

    function automatic string fmt(input snapT s);
        return $sformatf("c50=%0d c10=%0d c5=%0d c1=%0d item=%0d credit=%0d rej=%0b refund=%0b busy=%0b done=%0b fault=%0b",
                         s.c50, s.c10, s.c5, s.c1, s.item, s.credit, s.rej, s.refv, s.busy, s.done, s.fault);
    endfunction

    function automatic snapT sample();
        snapT s;
        s.c50 = bus.coinInNTD_50; s.c10 = bus.coinInNTD_10;
        s.c5 = bus.coinInNTD_5; s.c1 = bus.coinInNTD_1;
        s.item = bus.itemTypeIn; s.credit = bus.credit;
        s.rej = bus.coinReject; s.refv = bus.refundValid; s.busy = bus.busy;
        s.done = bus.txnDone; s.fault = bus.fault;
        return s;
    endfunction

    task automatic compare(input string label, input snapT got, input snapT exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got {%s} expected {%s}", label, cycleCount, fmt(got), fmt(exp));
        end
    endtask

    // Monitor: event-driven pops from evtQ, cycle-stamped pops from probeQ.
    initial begin
        snapT now;
        expT  e;
        logic [1:0] prevItem;
        logic       prevFault;
        logic       isEvent;
        prevItem  = 2'b00;
        prevFault = 1'b0;
        forever begin
            @(negedge clk);
            now = sample();
            isEvent = (now.rej === 1'b1) || (now.refv === 1'b1) || (now.done === 1'b1) ||
                      (now.fault === 1'b1 && prevFault !== 1'b1) ||
                      (now.item !== 2'b00 && !$isunknown(now.item) && prevItem === 2'b00);
            if (isEvent) begin
                if (evtQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpectedEvent at cycle %0d: got {%s} expected no event", cycleCount, fmt(now));
                end else begin
                    e = evtQ.pop_front();
                    compare(e.label, now, e.exp);
                end
            end
            while (probeQ.size() > 0 && probeQ[0].atCycle <= cycleCount) begin
                e = probeQ.pop_front();
                compare(e.label, now, e.exp);
            end
            prevItem  = now.item;
            prevFault = now.fault;
        end
    end

    task automatic applyStimulus(input logic cv, input logic [1:0] ct, input logic [1:0] sel,
                                 input logic canc, input logic [1:0] svc);
        bus.coinValid     = cv;
        bus.coinType      = ct;
        bus.itemSel       = sel;
        bus.cancel        = canc;
        bus.serviceTypeIn = svc;
        @(posedge clk);
        #1;
    endtask

    task automatic idleCycles(input int n, input logic [1:0] svc);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b00, 2'b00, 1'b0, svc);
    endtask

    task automatic checkOutput(input string label, input snapT exp);
        expT e;
        e.label = label; e.atCycle = cycleCount; e.exp = exp;
        probeQ.push_back(e);
    endtask

    task automatic expectEvent(input string label, input snapT exp);
        expT e;
        e.label = label; e.atCycle = 0; e.exp = exp;
        evtQ.push_back(e);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        idleCycles(2, 2'b00);
        checkOutput("resetState", mk(0,0,0,0, 0,0, 0,0,0,0,0));
        reset = 1'b1;

        // Normal purchase: 10+10+1, item A, core busy for 5 cycles then OFF.
        applyStimulus(1'b1, 2'b01, 2'b00, 1'b0, 2'b00);
        applyStimulus(1'b1, 2'b01, 2'b00, 1'b0, 2'b00);
        applyStimulus(1'b1, 2'b11, 2'b00, 1'b0, 2'b00);
        checkOutput("collect21", mk(0,2,0,1, 0,21, 0,0,0,0,0));
        expectEvent("issueA", mk(0,2,0,1, 1,21, 0,0,1,0,0));
        applyStimulus(1'b0, 2'b00, 2'b01, 1'b0, 2'b01);
        applyStimulus(1'b0, 2'b00, 2'b00, 1'b0, 2'b01);
        checkOutput("handoffA", mk(0,0,0,0, 0,0, 0,0,1,0,0));
        idleCycles(5, 2'b10);
        checkOutput("waitBusy", mk(0,0,0,0, 0,0, 0,0,1,0,0));
        expectEvent("txnDone", mk(0,0,0,0, 0,0, 0,0,0,1,0));
        idleCycles(1, 2'b00);
        idleCycles(1, 2'b00);
        checkOutput("afterDone", mk(0,0,0,0, 0,0, 0,0,0,0,0));

        // Saturation: fourth NTD50 is rejected.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 2'b00, 2'b00, 1'b0, 2'b00);
        checkOutput("three50", mk(3,0,0,0, 0,150, 0,0,0,0,0));
        expectEvent("reject50", mk(3,0,0,0, 0,150, 1,0,0,0,0));
        applyStimulus(1'b1, 2'b00, 2'b00, 1'b0, 2'b00);
        idleCycles(1, 2'b00);
        checkOutput("rejectPulseEnds", mk(3,0,0,0, 0,150, 0,0,0,0,0));
        expectEvent("refund150", mk(3,0,0,0, 0,150, 0,1,1,0,0));
        applyStimulus(1'b0, 2'b00, 2'b00, 1'b1, 2'b00);
        idleCycles(1, 2'b00);
        checkOutput("afterRefund150", mk(0,0,0,0, 0,0, 0,0,0,0,0));

        // Cancel together with a coin: the coin joins the refund.
        applyStimulus(1'b1, 2'b10, 2'b00, 1'b0, 2'b00);
        applyStimulus(1'b1, 2'b11, 2'b00, 1'b0, 2'b00);
        expectEvent("cancelRefund", mk(0,0,1,2, 0,7, 0,1,1,0,0));
        applyStimulus(1'b1, 2'b11, 2'b00, 1'b1, 2'b00);
        idleCycles(1, 2'b00);
        checkOutput("afterCancel", mk(0,0,0,0, 0,0, 0,0,0,0,0));

        // Inactivity timeout: nothing at 15 idle cycles, refund on the 16th.
        applyStimulus(1'b1, 2'b11, 2'b00, 1'b0, 2'b00);
        idleCycles(15, 2'b00);
        checkOutput("noRefundAt15", mk(0,0,0,1, 0,1, 0,0,0,0,0));
        expectEvent("timeoutRefund", mk(0,0,0,1, 0,1, 0,1,1,0,0));
        idleCycles(1, 2'b00);
        idleCycles(1, 2'b00);
        checkOutput("afterTimeout", mk(0,0,0,0, 0,0, 0,0,0,0,0));

        // Core stays BUSY: item held; coins rejected and cancel ignored in ISSUE.
        applyStimulus(1'b1, 2'b01, 2'b00, 1'b0, 2'b00);
        expectEvent("issueB", mk(0,1,0,0, 2,10, 0,0,1,0,0));
        applyStimulus(1'b0, 2'b00, 2'b10, 1'b0, 2'b10);
        idleCycles(4, 2'b10);
        checkOutput("issueHeld", mk(0,1,0,0, 2,10, 0,0,1,0,0));
        expectEvent("rejectInIssue", mk(0,1,0,0, 2,10, 1,0,1,0,0));
        applyStimulus(1'b1, 2'b01, 2'b00, 1'b0, 2'b10);
        applyStimulus(1'b0, 2'b00, 2'b00, 1'b1, 2'b10);
        checkOutput("cancelIgnored", mk(0,1,0,0, 2,10, 0,0,1,0,0));
        applyStimulus(1'b0, 2'b00, 2'b00, 1'b0, 2'b01);
        checkOutput("handoffB", mk(0,0,0,0, 0,0, 0,0,1,0,0));
        idleCycles(63, 2'b10);
        checkOutput("waitAt63", mk(0,0,0,0, 0,0, 0,0,1,0,0));
        expectEvent("faultRaised", mk(0,0,0,0, 0,0, 0,0,0,0,1));
        idleCycles(1, 2'b10);
        idleCycles(2, 2'b00);
        checkOutput("faultSticky", mk(0,0,0,0, 0,0, 0,0,0,0,1));

        // Reset in WAIT_DONE clears the sticky fault.
        applyStimulus(1'b1, 2'b00, 2'b00, 1'b0, 2'b00);
        expectEvent("issueC", mk(1,0,0,0, 3,50, 0,0,1,0,1));
        applyStimulus(1'b0, 2'b00, 2'b11, 1'b0, 2'b01);
        applyStimulus(1'b0, 2'b00, 2'b00, 1'b0, 2'b01);
        idleCycles(3, 2'b10);
        checkOutput("waitBeforeReset", mk(0,0,0,0, 0,0, 0,0,1,0,1));
        reset = 1'b0;
        idleCycles(1, 2'b10);
        checkOutput("resetInWait", mk(0,0,0,0, 0,0, 0,0,0,0,0));
        reset = 1'b1;

        // Reset in COLLECT with credit 60.
        applyStimulus(1'b1, 2'b00, 2'b00, 1'b0, 2'b00);
        applyStimulus(1'b1, 2'b01, 2'b00, 1'b0, 2'b00);
        checkOutput("collect60", mk(1,1,0,0, 0,60, 0,0,0,0,0));
        reset = 1'b0;
        applyStimulus(1'b0, 2'b00, 2'b01, 1'b0, 2'b01);
        checkOutput("resetInCollect", mk(0,0,0,0, 0,0, 0,0,0,0,0));
        reset = 1'b1;

        // IDLE ignores select and cancel with zero credit.
        applyStimulus(1'b0, 2'b00, 2'b01, 1'b0, 2'b01);
        applyStimulus(1'b0, 2'b00, 2'b00, 1'b1, 2'b00);
        idleCycles(1, 2'b00);
        checkOutput("idleIgnores", mk(0,0,0,0, 0,0, 0,0,0,0,0));

        idleCycles(3, 2'b00);
        while (evtQ.size() > 0) begin
            expT e;
            e = evtQ.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL %s: event never occurred, expected {%s}", e.label, fmt(e.exp));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
